// File: rtl/shift_rows.sv
// AES-128 ShiftRows / InvShiftRows stage with a registered output.
// Each output byte picks its forward or inverse source byte, then registers it.
module shift_rows (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         inv,
  input  logic [127:0] s1,
  output logic [127:0] s2,
  output logic         out_valid
);

  // Handshake: a state is accepted on every rising edge where in_valid=1 and
  // rst=0; out_valid is high for exactly one cycle per accepted state, one
  // cycle later. There is no ready/backpressure, so one state per clock.

  logic [127:0] shifted;

  // Byte k lives at row k%4, column k/4 (column-major, byte 0 is the MSByte).
  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int ROW = k % 4;
    localparam int COL = k / 4;
    localparam int FWD = ROW + 4 * ((COL + ROW) % 4);
    localparam int INV = ROW + 4 * ((COL + 4 - ROW) % 4);

    assign shifted[127-8*k -: 8] = inv ? s1[127-8*INV -: 8]
                                       : s1[127-8*FWD -: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2        <= 128'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s2 <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_shift_rows.sv
// Self-checking bench for shift_rows: directed FIPS/index vectors, streaming
// with mixed modes, reset cases, and random round-trip traffic.
module tb_shift_rows;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         inv;
  logic [127:0] s1;
  logic [127:0] s2;
  logic         out_valid;

  logic [127:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] last_exp;

  shift_rows dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inv       (inv),
    .s1        (s1),
    .s2        (s2),
    .out_valid (out_valid)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Row-rotation view of the state: row r rotates left by r (or right by r).
  function automatic logic [127:0] model(input logic [127:0] s, input logic m);
    logic [7:0] grid [4][4];
    logic [127:0] res;
    int sh;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        grid[r][c] = s[127-8*(4*c+r) -: 8];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      sh = m ? (4 - r) % 4 : r;
      for (int c = 0; c < 4; c++)
        res[127-8*(4*c+r) -: 8] = grid[r][(c + sh) % 4];
    end
    return res;
  endfunction

  // Driver: present one state for one cycle and record its expected result.
  task automatic send(input logic [127:0] s, input logic m,
                      input logic [127:0] e);
    in_valid = 1'b1;
    s1       = s;
    inv      = m;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard: compare every output pulse against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0)
        check_eq("spurious_out_valid", 128'(out_valid), 128'h0);
      else
        check_eq("s2", s2, exp_q.pop_front());
    end
  end

  initial begin
    logic [127:0] r;
    logic         m;

    // Reset with valid nonzero input: must be discarded.
    rst = 1'b1; in_valid = 1'b1; inv = 1'b0;
    s1 = 128'hd42711aee0bf98f1b8b45de51e415230;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_s2", s2, 128'h0);
    check_eq("reset_out_valid", 128'(out_valid), 128'h0);

    // Release with in_valid high: result one cycle later.
    rst = 1'b0;
    send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
         128'hd4bf5d30e0b452aeb84111f11e2798e5);
    idle(1);

    send(128'h000102030405060708090a0b0c0d0e0f, 1'b0,
         128'h00050a0f04090e03080d02070c01060b);
    send(128'h00050a0f04090e03080d02070c01060b, 1'b1,
         128'h000102030405060708090a0b0c0d0e0f);
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1,
         128'hd42711aee0bf98f1b8b45de51e415230);
    send({16{8'h5a}}, 1'b0, {16{8'h5a}});
    send({16{8'h5a}}, 1'b1, {16{8'h5a}});
    send(128'h00000000111111112222222233333333, 1'b0,
         128'h00112233112233002233001133001122);

    // Streaming with inv toggling 0,1,0,1, then idle: s2 must hold.
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      m = i[0];
      send(r, m, model(r, m));
    end
    idle(1);
    check_eq("hold_out_valid", 128'(out_valid), 128'h0);
    idle(1);
    check_eq("hold_s2", s2, last_exp);

    // Random traffic with random gaps, each followed by its round trip.
    for (int i = 0; i < 20; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      send(r, m, model(r, m));
      send(model(r, m), ~m, r);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    // Reset mid-stream: the state captured under reset is discarded.
    send(128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
         model(128'h0f0e0d0c0b0a09080706050403020100, 1'b0));
    rst = 1'b1; in_valid = 1'b1; s1 = 128'hffeeddccbbaa99887766554433221100;
    @(posedge clk); #1;
    check_eq("midreset_s2", s2, 128'h0);
    check_eq("midreset_out_valid", 128'(out_valid), 128'h0);
    rst = 1'b0;
    send(128'hffeeddccbbaa99887766554433221100, 1'b1,
         model(128'hffeeddccbbaa99887766554433221100, 1'b1));
    idle(3);

    check_eq("drain_queue_empty", 128'(exp_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
